// File: rtl/rv_dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the captured request record.
package rv_dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } t_mem_size;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_dmem_state;

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } t_dmem_req;

  // Encoding 2'b11 behaves as a word access.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_H) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/rv_dmem_if.sv
// Memory-stage request / write-back response bus between Q103H and Q104H.
interface rv_dmem_if;
  logic        req_valid_Q103H;
  logic        req_ready_Q103H;
  logic        req_wr_Q103H;
  logic [31:0] req_addr_Q103H;
  logic [1:0]  req_size_Q103H;
  logic        req_unsigned_Q103H;
  logic [31:0] req_wdata_Q103H;
  logic        rsp_valid_Q104H;
  logic [31:0] rsp_rdata_Q104H;
  logic        rsp_err_Q104H;

  modport master (
    output req_valid_Q103H, req_wr_Q103H, req_addr_Q103H, req_size_Q103H,
           req_unsigned_Q103H, req_wdata_Q103H,
    input  req_ready_Q103H, rsp_valid_Q104H, rsp_rdata_Q104H, rsp_err_Q104H
  );

  modport slave (
    input  req_valid_Q103H, req_wr_Q103H, req_addr_Q103H, req_size_Q103H,
           req_unsigned_Q103H, req_wdata_Q103H,
    output req_ready_Q103H, rsp_valid_Q104H, rsp_rdata_Q104H, rsp_err_Q104H
  );
endinterface

// File: rtl/rv_dmem_align.sv
// Byte-lane steering: store replication + byte enables, load lane select
// with sign/zero extension.
module rv_dmem_align
  import rv_dmem_pkg::*;
(
  input  logic [1:0]                  size,
  input  logic [1:0]                  lo,
  input  logic                        uns,
  input  logic [31:0]                 wdata,
  input  logic [31:0]                 rword,
  output logic [NUM_LANES-1:0]        be,
  output logic [NUM_LANES-1:0][7:0]   wlanes,
  output logic [31:0]                 rdata
);
  logic [NUM_LANES-1:0] be_base;
  logic [31:0]          shifted;

  always_comb begin
    be_base = 4'b1111;
    case (size)
      SIZE_B:  be_base = 4'b0001;
      SIZE_H:  be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end

  assign be = be_base << lo;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    always_comb begin
      wlanes[g] = wdata[8*g +: 8];
      case (size)
        SIZE_B:  wlanes[g] = wdata[7:0];
        SIZE_H:  wlanes[g] = wdata[8*(g%2) +: 8];
        default: wlanes[g] = wdata[8*g +: 8];
      endcase
    end
  end

  assign shifted = rword >> {lo, 3'b000};

  always_comb begin
    rdata = rword;
    case (size)
      SIZE_B:  rdata = {{24{~uns & shifted[7]}},  shifted[7:0]};
      SIZE_H:  rdata = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: rdata = rword;
    endcase
  end
endmodule

// File: rtl/rv_dmem.sv
// Data-memory responder: one load/store per handshake, WAIT_STATES extra
// cycles, single-cycle response carrying extended load data or an error.
module rv_dmem
  import rv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic     clk,
  input  logic     rst,
  rv_dmem_if.slave bus,
  output logic     busy
);
  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L   = 30'(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  t_dmem_state state, state_nx;
  logic [2:0]  wait_cnt, wait_cnt_nx;
  t_dmem_req   live, cap, op;
  logic        accept, to_resp, op_err;
  logic [IDX_W-1:0]            op_idx;
  logic [NUM_LANES-1:0]        be;
  logic [NUM_LANES-1:0][7:0]   wlanes;
  logic [31:0]                 rword, rext;
  logic [NUM_LANES-1:0][7:0]   mem [DEPTH_WORDS];

  assign bus.req_ready_Q103H = (state == IDLE) || (state == RESP);
  assign accept              = bus.req_valid_Q103H && bus.req_ready_Q103H;
  assign bus.rsp_valid_Q104H = (state == RESP);
  assign busy                = (state == WAIT);

  assign live = {bus.req_wr_Q103H, bus.req_addr_Q103H, bus.req_size_Q103H,
                 bus.req_unsigned_Q103H, bus.req_wdata_Q103H};

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx    = WAIT;
            wait_cnt_nx = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 3'd0) state_nx = RESP;
        else                  wait_cnt_nx = wait_cnt - 3'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) cap <= live;
  end

  // Zero wait states perform the access on the accept edge itself, so the
  // operation comes straight from the bus; otherwise from the captured copy.
  assign op      = (state == WAIT) ? cap : live;
  assign to_resp = (state_nx == RESP);
  assign op_err  = align_err(op.size, op.addr[1:0]) || (op.addr[31:2] >= DEPTH_L);
  assign op_idx  = op.addr[IDX_W+1:2];
  assign rword   = mem[op_idx];

  rv_dmem_align u_align (
    .size  (op.size),
    .lo    (op.addr[1:0]),
    .uns   (op.uns),
    .wdata (op.wdata),
    .rword (rword),
    .be    (be),
    .wlanes(wlanes),
    .rdata (rext)
  );

  always_ff @(posedge clk) begin
    if (to_resp && op.wr && !op_err) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be[b]) mem[op_idx][b] <= wlanes[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_rdata_Q104H <= 32'd0;
      bus.rsp_err_Q104H   <= 1'b0;
    end else if (to_resp) begin
      bus.rsp_err_Q104H   <= op_err;
      bus.rsp_rdata_Q104H <= (op.wr || op_err) ? 32'd0 : rext;
    end
  end
endmodule

// File: tb/tb_rv_dmem.sv
// Scoreboard bench: zero-wait and three-wait responders driven by directed
// vectors; a negedge monitor pops expected responses as they appear.
module tb_rv_dmem;
  import rv_dmem_pkg::*;

  logic clk = 1'b0;
  logic rst0 = 1'b0, rst3 = 1'b0;
  logic busy0, busy3;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v [2];
  logic        wr[2];
  logic        un[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic [1:0]  sz[2];

  rv_dmem_if i0();
  rv_dmem_if i3();

  assign i0.req_valid_Q103H    = v[0];
  assign i0.req_wr_Q103H       = wr[0];
  assign i0.req_addr_Q103H     = ad[0];
  assign i0.req_size_Q103H     = sz[0];
  assign i0.req_unsigned_Q103H = un[0];
  assign i0.req_wdata_Q103H    = wd[0];
  assign i3.req_valid_Q103H    = v[1];
  assign i3.req_wr_Q103H       = wr[1];
  assign i3.req_addr_Q103H     = ad[1];
  assign i3.req_size_Q103H     = sz[1];
  assign i3.req_unsigned_Q103H = un[1];
  assign i3.req_wdata_Q103H    = wd[1];

  rv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst0), .bus(i0.slave), .busy(busy0));
  rv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (.clk(clk), .rst(rst3), .bus(i3.slave), .busy(busy3));

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (i0.rsp_valid_Q104H) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL rsp0: unexpected response at cycle %0d", cyc);
      end else begin
        e = q0.pop_front();
        if (cyc != e.due || i0.rsp_err_Q104H !== e.err || i0.rsp_rdata_Q104H !== e.rdata) begin
          n_bad++;
          $display("FAIL rsp0: got cyc %0d err %b data %h want cyc %0d err %b data %h",
                   cyc, i0.rsp_err_Q104H, i0.rsp_rdata_Q104H, e.due, e.err, e.rdata);
        end
      end
    end
    if (i3.rsp_valid_Q104H) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_bad++;
        $display("FAIL rsp3: unexpected response at cycle %0d", cyc);
      end else begin
        e = q3.pop_front();
        if (cyc != e.due || i3.rsp_err_Q104H !== e.err || i3.rsp_rdata_Q104H !== e.rdata) begin
          n_bad++;
          $display("FAIL rsp3: got cyc %0d err %b data %h want cyc %0d err %b data %h",
                   cyc, i3.rsp_err_Q104H, i3.rsp_rdata_Q104H, e.due, e.err, e.rdata);
        end
      end
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? i0.req_ready_Q103H : i3.req_ready_Q103H;
  endfunction

  // Called just after a rising edge; returns the cycle number of the accept edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] dat, input logic e_err,
                       input logic [31:0] e_rd, input bit push, output int acc);
    exp_t e;
    v[d] = 1'b1; wr[d] = w; ad[d] = a; sz[d] = s; un[d] = u; wd[d] = dat;
    for (int k = 0; k < 50; k++) begin
      if (rdy(d)) break;
      @(posedge clk); #1;
    end
    acc = cyc + 1;
    if (!rdy(d)) begin
      n_cmp++; n_bad++;
      $display("FAIL accept%0d: ready never rose, addr %h", d, a);
    end else if (push) begin
      e.due = acc + ((d == 0) ? 0 : 3);
      e.err = e_err;
      e.rdata = e_rd;
      if (d == 0) q0.push_back(e);
      else        q3.push_back(e);
    end
    @(posedge clk); #1;
    v[d] = 1'b0;
  endtask

  initial begin
    int a1, a2, a3, a4;
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; wr[d] = 1'b0; un[d] = 1'b0; ad[d] = '0; wd[d] = '0; sz[d] = SIZE_W;
    end
    fork
      forever @(negedge clk) monitor();
      begin
        repeat (2) @(posedge clk); #1;
        chk("rst0_valid", 32'(i0.rsp_valid_Q104H), 32'd0);
        chk("rst0_err",   32'(i0.rsp_err_Q104H),   32'd0);
        chk("rst0_rdata", i0.rsp_rdata_Q104H,      32'd0);
        chk("rst0_busy",  32'(busy0),              32'd0);
        chk("rst0_ready", 32'(i0.req_ready_Q103H), 32'd1);
        chk("rst3_ready", 32'(i3.req_ready_Q103H), 32'd1);
        rst0 = 1'b1; rst3 = 1'b1;
        @(posedge clk); #1;

        // zero wait states, back-to-back
        issue(0, 1, 32'h10,  SIZE_W, 0, 32'hDEADBEEF, 0, 32'h0,        1, a1);
        issue(0, 0, 32'h10,  SIZE_W, 0, 32'h0,        0, 32'hDEADBEEF, 1, a1);
        issue(0, 0, 32'h13,  SIZE_B, 0, 32'h0,        0, 32'hFFFFFFDE, 1, a1);
        issue(0, 0, 32'h13,  SIZE_B, 1, 32'h0,        0, 32'h000000DE, 1, a1);
        issue(0, 1, 32'h12,  SIZE_H, 0, 32'h00001234, 0, 32'h0,        1, a1);
        issue(0, 0, 32'h10,  SIZE_W, 0, 32'h0,        0, 32'h1234BEEF, 1, a1);
        issue(0, 0, 32'h12,  SIZE_H, 0, 32'h0,        0, 32'h00001234, 1, a1);
        issue(0, 0, 32'h10,  SIZE_H, 0, 32'h0,        0, 32'hFFFFBEEF, 1, a1);
        issue(0, 1, 32'h14,  SIZE_W, 0, 32'hCAFEF00D, 0, 32'h0,        1, a1);
        issue(0, 0, 32'h11,  SIZE_W, 0, 32'h0,        1, 32'h0,        1, a1);
        issue(0, 1, 32'h15,  SIZE_H, 0, 32'h0000AAAA, 1, 32'h0,        1, a1);
        issue(0, 0, 32'h14,  SIZE_W, 0, 32'h0,        0, 32'hCAFEF00D, 1, a1);
        issue(0, 0, 32'h15,  SIZE_B, 0, 32'h0,        0, 32'hFFFFFFF0, 1, a1);
        issue(0, 1, 32'h16,  SIZE_B, 0, 32'h00000077, 0, 32'h0,        1, a1);
        issue(0, 0, 32'h14,  2'b11,  0, 32'h0,        0, 32'hCA77F00D, 1, a1);
        issue(0, 0, 32'h17,  SIZE_H, 1, 32'h0,        1, 32'h0,        1, a1);
        issue(0, 1, 32'h1000,SIZE_W, 0, 32'h00000001, 1, 32'h0,        1, a1);
        issue(0, 0, 32'h1000,SIZE_W, 0, 32'h0,        1, 32'h0,        1, a1);
        issue(0, 1, 32'hFFC, SIZE_W, 0, 32'h11223344, 0, 32'h0,        1, a1);
        issue(0, 0, 32'hFFE, SIZE_H, 1, 32'h0,        0, 32'h00001122, 1, a1);
        issue(0, 0, 32'hFFC, SIZE_B, 0, 32'h0,        0, 32'h00000044, 1, a1);
        repeat (3) @(posedge clk); #1;

        // three wait states: requests held off until RESP
        issue(1, 1, 32'h20, SIZE_W, 0, 32'h55667788, 0, 32'h0, 1, a1);
        chk("wait_ready", 32'(i3.req_ready_Q103H), 32'd0);
        chk("wait_busy",  32'(busy3),              32'd1);
        issue(1, 0, 32'h20, SIZE_W, 0, 32'h0, 0, 32'h55667788, 1, a2);
        chk("held_accept", 32'(a2), 32'(a1 + 4));
        issue(1, 0, 32'h21, SIZE_B, 0, 32'h0, 0, 32'h00000077, 1, a3);
        chk("held_accept2", 32'(a3), 32'(a2 + 4));
        repeat (6) @(posedge clk); #1;

        // reset while a store sits in WAIT: no response, no write
        issue(1, 1, 32'h20, SIZE_W, 0, 32'h99999999, 0, 32'h0, 0, a4);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy3), 32'd1);
        rst3 = 1'b0;
        #1;
        chk("rst_ready", 32'(i3.req_ready_Q103H), 32'd1);
        chk("rst_busy",  32'(busy3),              32'd0);
        chk("rst_valid", 32'(i3.rsp_valid_Q104H), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        issue(1, 0, 32'h20, SIZE_W, 0, 32'h0, 0, 32'h55667788, 1, a4);
        repeat (8) @(posedge clk); #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_dmem.md
# rv_dmem

Data-memory responder on the far side of the pipeline's memory-access interface: it accepts one load or store request per handshake from the Q103H memory stage, performs it against an internal word-organised array after a configurable number of wait states, and returns a single-cycle response carrying aligned, sign- or zero-extended load data or an error flag. It is the D_MEM that the memory stage drives. Load responses are consumed by write-back; store responses only retire the request.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; legal word index is addr[31:2] < DEPTH_WORDS.
- WAIT_STATES, 0: extra cycles between accept and response; legal range 0..7.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid_Q103H  in  1  request present.
- req_ready_Q103H  out  1  responder can accept this cycle.
- req_wr_Q103H  in  1  1 = store, 0 = load.
- req_addr_Q103H  in  32  byte address.
- req_size_Q103H  in  2  t_mem_size: SIZE_B, SIZE_H, SIZE_W.
- req_unsigned_Q103H  in  1  zero-extend the load (LBU/LHU).
- req_wdata_Q103H  in  32  store data, right-justified.
- rsp_valid_Q104H  out  1  one-cycle response pulse.
- rsp_rdata_Q104H  out  32  extended load data; 0 for stores and errors.
- rsp_err_Q104H  out  1  misaligned or out-of-range request.
- busy  out  1  request accepted and response not yet issued.

## Operation
- States: IDLE, WAIT, RESP (t_dmem_state).
- req_ready_Q103H = (state == IDLE) || (state == RESP).
- Accept = req_valid && req_ready. On accept, addr/size/wr/unsigned/wdata are captured. Next state is RESP if WAIT_STATES == 0; otherwise WAIT with wait_cnt = WAIT_STATES − 1.
- WAIT: decrement wait_cnt each cycle and go to RESP when wait_cnt == 0. Inputs are ignored.
- RESP: rsp_valid_Q104H = 1 for exactly this cycle. If there is no new accept, next state is IDLE; an accept in RESP follows the same rule as in IDLE.
- Error check on the captured request:
  - SIZE_H with addr[0] = 1 is an error.
  - SIZE_W with addr[1:0] ≠ 0 is an error.
  - Word index ≥ DEPTH_WORDS is an error.
  - An error gives rsp_err = 1 and rdata = 0, and the array is not written.
- Store: byte enables are 0001 for byte, 0011 for half, 1111 for word, shifted left by addr[1:0]. wdata lanes are replicated (byte ×4, half ×2). Only enabled bytes are written, on the clock edge entering RESP.
- Load: the word is read on the edge entering RESP. The lane is selected by addr[1:0], then sign-extended from bit 7/15 unless unsigned. The result is registered into rsp_rdata_Q104H.
- Read-after-write: a load accepted in a store's RESP cycle returns the newly written data.
- Encoding 2'b11 of req_size is treated as SIZE_W.

## Timing
- Accept at edge N gives rsp_valid high during cycle N+1+WAIT_STATES.
- WAIT_STATES = 0: full throughput, one request per cycle, with ready held high.
- WAIT_STATES = k: one request per k+1 cycles.
- Reset (rst low, asynchronous) values:
  - state = IDLE, wait_cnt = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - req_ready is 1 once state is IDLE.
  - Array contents are not reset.
- Reset mid-operation drops any in-flight request with no response. An in-flight store that has not yet reached RESP is not written.
- rsp outputs other than rsp_valid hold their last value until the next response.

## Structure
- In pkg: t_mem_size enum, t_dmem_state enum, and SIZE_* constants.
- Sub-module rv_dmem_align (combinational) performs store lane replication and byte-enable generation, and load lane extraction with sign/zero extension.
- The array is a behavioural reg array with per-byte write enables, with no reset.

## Test plan
- WAIT_STATES = 0: store word 0xDEADBEEF at 0x10, then load word 0x10 back-to-back. Response is err = 0, rdata = 0xDEADBEEF, one cycle after the load accept.
- Load byte at 0x13 signed, then unsigned, from the 0x10 word above. Responses are 0xFFFFFFDE and 0x000000DE.
- Store half 0x1234 at 0x12, then load word 0x10. Response is 0x1234BEEF. Load half 0x12 signed returns 0x00001234.
- Misaligned requests: load word 0x11 and store half 0x15. Each gives rsp_err = 1 and rdata = 0, and memory at 0x14 is unchanged.
- WAIT_STATES = 3: rsp_valid comes 4 cycles after accept. ready = 0 and busy = 1 during WAIT, and a second valid request is held until RESP.
- Assert rst during WAIT of a store to 0x20. No rsp_valid follows, ready = 1 after reset, and a later load from 0x20 returns the pre-store value.
